// File: rtl/pkg_defines.sv
// Shared definitions for the memory arbiter: FSM state type, default bus
// widths and a helper for sizing channel-index fields.
package pkg_defines;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 128;

    // Width of a channel index; a single-channel build still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin picker: scans the request vector starting at
// i_ptr, ascending with wrap, and returns the first requesting channel.
module round_robin_picker #(
    parameter int CHANNELS = 2,
    parameter int PTR_W    = 1
) (
    input  logic [CHANNELS-1:0] i_req,
    input  logic [PTR_W-1:0]    i_ptr,
    output logic [PTR_W-1:0]    o_grant,
    output logic                o_valid
);

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        int idx;
        idx     = 0;
        o_valid = 1'b0;
        o_grant = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            idx = int'(i_ptr) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (i_req[idx]) begin
                o_valid = 1'b1;
                o_grant = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory port between CHANNELS requesters.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to abort a BUSY transaction
// after MEM_TIMEOUT cycles without i_mem_ready (flagged on o_error).
module memory_arbiter
    import pkg_defines::*;
#(
    parameter int CHANNELS    = 2,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                           i_clock,
    input  logic                           i_reset,
    input  logic [CHANNELS-1:0]            i_req,
    input  logic [CHANNELS-1:0]            i_we,
    input  logic [CHANNELS*ADDR_WIDTH-1:0] i_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] i_wdata,
    output logic [CHANNELS-1:0]            o_ack,
    output logic [CHANNELS-1:0]            o_error,
    output logic [DATA_WIDTH-1:0]          o_rdata,
    output logic                           o_mem_req,
    output logic                           o_mem_we,
    output logic [ADDR_WIDTH-1:0]          o_mem_addr,
    output logic [DATA_WIDTH-1:0]          o_mem_wdata,
    input  logic                           i_mem_ready,
    input  logic [DATA_WIDTH-1:0]          i_mem_rdata
);

    localparam int PTR_W = ptr_width(CHANNELS);
    localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(CHANNELS - 1);

    arb_state_t             r_state;
    logic [PTR_W-1:0]       r_ptr;
    logic [PTR_W-1:0]       r_grant;
    logic [PTR_W-1:0]       w_grant;
    logic                   w_valid;
    logic [PTR_W-1:0]       w_ptr_next;
    logic [CHANNELS-1:0]    w_ack_onehot;
    logic [ADDR_WIDTH-1:0]  w_addr_arr  [CHANNELS];
    logic [DATA_WIDTH-1:0]  w_wdata_arr [CHANNELS];

    // Unpack the flat per-channel operand buses into indexable arrays.
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = i_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[gi] = i_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    round_robin_picker #(
        .CHANNELS (CHANNELS),
        .PTR_W    (PTR_W)
    ) u_picker (
        .i_req   (i_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    // Pointer advances past the served channel; explicit wrap handles
    // channel counts that are not a power of two.
    assign w_ptr_next   = (r_grant == LAST_CH) ? '0 : r_grant + 1'b1;
    assign w_ack_onehot = CHANNELS'(1) << r_grant;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(MEM_TIMEOUT - 1);
    logic [TMR_W-1:0] r_timer;
`else
    // Watchdog compiled out: the error flag can never be raised.
    logic [31:0] w_unused_timeout;
    assign w_unused_timeout = 32'(MEM_TIMEOUT);
    assign o_error          = '0;
`endif

    // Arbitration FSM; every output is a register updated here.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            o_ack       <= '0;
            o_rdata     <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            o_error     <= '0;
            r_timer     <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_grant     <= w_grant;
                        o_mem_req   <= 1'b1;
                        o_mem_we    <= i_we[w_grant];
                        o_mem_addr  <= w_addr_arr[w_grant];
                        o_mem_wdata <= w_wdata_arr[w_grant];
                        r_state     <= BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                        r_timer     <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (i_mem_ready) begin
                        o_mem_req <= 1'b0;
                        if (!o_mem_we) begin
                            o_rdata <= i_mem_rdata;
                        end
                        o_ack   <= w_ack_onehot;
                        r_state <= DONE;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (r_timer == TMO_LAST) begin
                        o_mem_req <= 1'b0;
                        o_rdata   <= '0;
                        o_ack     <= w_ack_onehot;
                        o_error   <= w_ack_onehot;
                        r_state   <= DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
`endif
                end
                DONE: begin
                    o_ack   <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    o_error <= '0;
`endif
                    r_ptr   <= w_ptr_next;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 2, giving the number of requester channels (legal range 1-8; channel 0 is the instruction cache and channel 1 the data cache).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, giving the memory address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 128, giving the line transfer width in bits.
REQ-004 The block SHALL have parameter MEM_TIMEOUT, default 64, giving the watchdog limit in cycles.
REQ-005 The block SHALL have port i_clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port i_req, input, CHANNELS bits: per-channel request.
REQ-008 The block SHALL have port i_we, input, CHANNELS bits: per-channel write enable.
REQ-009 The block SHALL have port i_addr, input, CHANNELS x ADDR_WIDTH: per-channel address.
REQ-010 The block SHALL have port i_wdata, input, CHANNELS x DATA_WIDTH: per-channel write line.
REQ-011 The block SHALL have port o_ack, output, CHANNELS bits: one-cycle completion pulse.
REQ-012 The block SHALL have port o_error, output, CHANNELS bits: completion-with-timeout flag, valid with o_ack.
REQ-013 The block SHALL have port o_rdata, output, DATA_WIDTH bits: read line, shared by all channels and valid with o_ack.
REQ-014 The block SHALL have port o_mem_req, output, 1 bit: memory request.
REQ-015 The block SHALL have port o_mem_we, output, 1 bit: memory write enable.
REQ-016 The block SHALL have ports o_mem_addr (output, ADDR_WIDTH) and o_mem_wdata (output, DATA_WIDTH).
REQ-017 The block SHALL have ports i_mem_ready (input, 1 bit: memory done) and i_mem_rdata (input, DATA_WIDTH).

Function
REQ-018 The FSM SHALL have three states, IDLE, BUSY and DONE, with all outputs registered.
REQ-019 IDLE: if any i_req bit is set, the FSM SHALL select one channel by round-robin, latch that channel's we/addr/wdata, and enter BUSY; otherwise it SHALL stay in IDLE.
REQ-020 Round-robin: the search SHALL start at pointer ptr and ascend with wrap (CHANNELS-1 -> 0); ptr SHALL update to granted+1 mod CHANNELS on leaving DONE.
REQ-021 BUSY: o_mem_req SHALL be 1, and o_mem_we/o_mem_addr/o_mem_wdata SHALL hold the latched values until i_mem_ready is sampled high.
REQ-022 On the first BUSY cycle with i_mem_ready=1, the FSM SHALL capture i_mem_rdata (reads only; writes leave o_rdata unchanged) and enter DONE.
REQ-023 DONE: o_ack[granted] SHALL be 1 for exactly one cycle, o_mem_req SHALL be 0, and the FSM SHALL then return to IDLE.
REQ-024 Minimum latency SHALL be: i_req high in cycle 0 (IDLE), o_mem_req in cycle 1, i_mem_ready in cycle 1, o_ack in cycle 2.
REQ-025 Requesters SHALL hold i_req and operands stable until o_ack and deassert from the following cycle; changes to i_req/operands during BUSY SHALL be ignored.
REQ-026 A requester that drops i_req before grant SHALL lose the request; i_mem_ready outside BUSY SHALL be ignored.
REQ-027 When CHANNELS=1, the block SHALL grant channel 0 unconditionally when requested.

Reset
REQ-028 While i_reset=1 at a clock edge, the block SHALL go to IDLE with ptr=0, o_ack=0, o_error=0, o_rdata=0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, and timeout counter=0.
REQ-029 A reset during BUSY or DONE SHALL abort the transaction with no ack issued; memory sees o_mem_req drop in the next cycle.

Configuration
REQ-030 Macro MEM_ARB_TIMEOUT_EN defined: a counter SHALL run in BUSY; if MEM_TIMEOUT cycles elapse without i_mem_ready, the FSM SHALL enter DONE with o_error[granted]=1 and o_rdata=0.
REQ-031 Macro MEM_ARB_TIMEOUT_EN undefined: there SHALL be no counter, BUSY SHALL wait indefinitely, and o_error SHALL be tied to 0 (the port remains).

Structure
REQ-032 pkg_defines SHALL hold the typedef arb_state_t {IDLE, BUSY, DONE} and the default constants for ADDR_WIDTH and DATA_WIDTH.
REQ-033 One sub-module, round_robin_picker, SHALL be used: combinational, taking request vector and ptr, returning grant index and valid.

Verification
REQ-034 Verification SHALL cover: reset; then ch0 read at 0x100, memory ready 1 cycle later with rdata 0xA5.. -> o_ack[0] in cycle 2, o_rdata=0xA5.., o_error=0.
REQ-035 Verification SHALL cover: ch0 and ch1 requesting in the same cycle, ptr=0 -> ch0 served first, then ch1, with o_mem_addr switching from ch0's to ch1's address.
REQ-036 Verification SHALL cover: ch1 write to 0x200 with wdata 0x1234 and i_mem_ready delayed 5 cycles -> o_mem_we=1 and stable operands for 5 BUSY cycles, then o_ack[1].
REQ-037 Verification SHALL cover: CHANNELS=4, all requesting continuously -> grant order 0,1,2,3,0 with no starvation.
REQ-038 Verification SHALL cover: with MEM_ARB_TIMEOUT_EN and MEM_TIMEOUT=8, no ready -> o_ack and o_error set 8 cycles after BUSY entry, o_rdata=0.
REQ-039 Verification SHALL cover: i_reset in the 3rd BUSY cycle -> no o_ack, o_mem_req=0 in the next cycle, and the next request is granted to ch0.
